// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame states, opcodes and widths
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        CMD,
        SHIFT,
        HOLD,
        WAIT,
        RECV,
        END
    } spi_state_t;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/spi_shifter.sv
// rtl/spi_shifter.sv - parallel-load, MSB-first serial shift register with bit counter
module spi_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift_en,
    input  logic         sin,
    output logic [W-1:0] data,
    output logic         last
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            cnt  <= 4'd0;
        end else if (load) begin
            data <= load_data;
            cnt  <= 4'(W);
        end else if (shift_en) begin
            data <= {data[W-2:0], sin};
            cnt  <= cnt - 4'd1;
        end
    end

    // High during the final shift of a W-bit run.
    assign last = (cnt == 4'd1);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI frame master: 10-bit command out, optional 8-bit read-back
module spi_master
    import spi_pkg::*;
#(
    parameter int RD_WAIT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] cmd,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    spi_state_t state, next_state;

    logic [1:0]            op_q;
    logic [3:0]            wait_cnt;
    logic [FRAME_BITS-1:0] tx_data;
    logic [DATA_BITS-1:0]  rx_data;
    logic                  tx_last;
    logic                  rx_last;
    logic                  accept;
    logic                  mosi_next;
    logic                  unused_bits;

    assign accept = (state == IDLE) && start;

    spi_shifter #(.W(FRAME_BITS)) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (cmd),
        .shift_en  (state == SHIFT),
        .sin       (1'b0),
        .data      (tx_data),
        .last      (tx_last)
    );

    spi_shifter #(.W(DATA_BITS)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      ((state == WAIT) && (next_state == RECV)),
        .load_data ('0),
        .shift_en  (state == RECV),
        .sin       (MISO),
        .data      (rx_data),
        .last      (rx_last)
    );

    assign unused_bits = ^{tx_data[FRAME_BITS-3:0], rx_data[DATA_BITS-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mosi_next  = 1'b0;
        case (state)
            IDLE:    if (start) next_state = START;
            START:   next_state = CMD;
            CMD:     next_state = SHIFT;
            SHIFT:   if (tx_last) next_state = (op_q == RD_DATA) ? WAIT : HOLD;
            HOLD:    next_state = END;
            WAIT:    if (wait_cnt == 4'd0) next_state = RECV;
            RECV:    if (rx_last) next_state = END;
            END:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // MOSI is registered, so pick the bit that belongs to the upcoming cycle;
        // once shifting, the next bit sits one below the MSB until this edge's shift.
        if (next_state == CMD) begin
            mosi_next = tx_data[FRAME_BITS-1];
        end else if (next_state == SHIFT) begin
            mosi_next = (state == SHIFT) ? tx_data[FRAME_BITS-2] : tx_data[FRAME_BITS-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 2'b00;
            wait_cnt <= 4'd0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (accept) op_q <= cmd[9:8];
            if ((state == SHIFT) && (next_state == WAIT)) begin
                wait_cnt <= 4'(RD_WAIT - 1);
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            SS_n     <= (next_state == IDLE) || (next_state == END);
            MOSI     <= mosi_next;
            busy     <= (next_state != IDLE);
            done     <= (next_state == END);
            rd_valid <= (next_state == END) && (op_q == RD_DATA);
            // The eighth MISO sample lands on the same edge that leaves RECV.
            if ((state == RECV) && (next_state == END)) begin
                rd_data <= {rx_data[DATA_BITS-2:0], MISO};
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master with a behavioural SPI slave
module tb_spi_master;
    import spi_pkg::*;

    localparam int RD_WAIT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] cmd = 10'd0;
    logic       MISO;
    logic       busy, done, rd_valid, SS_n, MOSI;
    logic [7:0] rd_data;

    spi_master #(.RD_WAIT(RD_WAIT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cmd      (cmd),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural slave: decodes frames by cycle position under SS_n and serves reads.
    int         s_cyc = 0;
    logic [9:0] s_sh = 10'd0;
    logic [1:0] s_op = 2'b00;
    logic [7:0] s_addr = 8'd0;
    logic [7:0] s_mem [256];
    logic [7:0] s_byte;

    always @(negedge clk) begin
        if (SS_n) begin
            s_cyc = 0;
            MISO  = 1'b0;
        end else begin
            s_cyc++;
            if (s_cyc >= 3 && s_cyc <= 12) s_sh = {s_sh[8:0], MOSI};
            if (s_cyc == 12) begin
                s_op = s_sh[9:8];
                case (s_op)
                    WR_ADDR: s_addr = s_sh[7:0];
                    WR_DATA: s_mem[s_addr] = s_sh[7:0];
                    RD_ADDR: s_addr = s_sh[7:0];
                    default: ;
                endcase
            end
            if (s_op == RD_DATA && s_cyc >= 13 + RD_WAIT && s_cyc <= 20 + RD_WAIT) begin
                s_byte = s_mem[s_addr];
                MISO = s_byte[7 - (s_cyc - 13 - RD_WAIT)];
            end else begin
                MISO = 1'b0;
            end
        end
    end

    logic ss_bad = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(!SS_n && !busy)) else begin
                ss_bad = 1'b1;
                $error("FAIL ss_low_while_idle observed SS_n=%b busy=%b expected busy=1", SS_n, busy);
            end
        end
    end

    // Reference model of the addressed register file behind the slave.
    logic [7:0] r_mem [256];
    logic [7:0] r_addr = 8'd0;
    logic [7:0] r_rd = 8'd0;

    task automatic ref_apply(input logic [9:0] c);
        case (c[9:8])
            WR_ADDR: r_addr = c[7:0];
            WR_DATA: r_mem[r_addr] = c[7:0];
            RD_ADDR: r_addr = c[7:0];
            default: r_rd = r_mem[r_addr];
        endcase
    endtask

    task automatic run_frame(input logic [9:0] c);
        int low = 0, done_at = 0, done_cnt = 0, rv_cnt = 0, rv_alone = 0;
        logic [12:0] mosi_obs = 13'd0;
        logic [12:0] mosi_exp;
        logic busy1 = 1'b0;
        bit is_rd;
        is_rd = (c[9:8] == RD_DATA);
        mosi_exp = {1'b0, c[9], c, 1'b0};
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        cmd   = c;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                busy1 = busy;
                start = 1'b0;
                cmd   = 10'($urandom);
            end
            if (k <= 13) mosi_obs = {mosi_obs[11:0], MOSI};
            if (!SS_n) low++;
            if (done) begin done_cnt++; done_at = k; end
            if (rd_valid) begin rv_cnt++; if (!done) rv_alone++; end
        end
        ref_apply(c);
        chk("busy_after_accept", 32'(busy1), 32'd1);
        chk("mosi_seq", 32'(mosi_obs), 32'(mosi_exp));
        chk("ss_low_cycles", 32'(low), is_rd ? 32'(20 + RD_WAIT) : 32'd13);
        chk("done_cycle", 32'(done_at), is_rd ? 32'(21 + RD_WAIT) : 32'd14);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("rd_valid_pulses", 32'(rv_cnt), is_rd ? 32'd1 : 32'd0);
        chk("rd_valid_without_done", 32'(rv_alone), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("rd_data", 32'(rd_data), 32'(r_rd));
    endtask

    initial begin
        logic [1:0] op;
        logic [7:0] pl;
        int ss_prev, rise, fall2, done_cnt, first_done, bad_rd;
        for (int i = 0; i < 256; i++) begin
            s_mem[i] = 8'd0;
            r_mem[i] = 8'd0;
        end

        repeat (2) @(negedge clk);
        chk("reset_ss_n", 32'(SS_n), 32'd1);
        chk("reset_mosi", 32'(MOSI), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);

        // Directed: first start right after reset release, then the documented frames.
        run_frame({WR_ADDR, 8'hA5});
        run_frame({WR_DATA, 8'hC3});
        run_frame({RD_ADDR, 8'hA5});
        run_frame({RD_DATA, 8'h00});
        chk("rd_c3", 32'(rd_data), 32'hC3);

        run_frame({WR_ADDR, 8'h10});
        run_frame({WR_DATA, 8'h5A});
        run_frame({RD_ADDR, 8'h10});
        run_frame({WR_ADDR, 8'h33});
        chk("rd_hold_over_writes", 32'(rd_data), 32'hC3);
        run_frame({RD_ADDR, 8'h10});
        run_frame({RD_DATA, 8'hFF});
        chk("rd_5a", 32'(rd_data), 32'h5A);

        // Back-to-back wr-data frames with start held high throughout.
        ss_prev = 1; rise = 0; fall2 = 0; done_cnt = 0; first_done = 0;
        @(negedge clk);
        start = 1'b1;
        cmd   = {WR_DATA, 8'h11};
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 14) cmd = {WR_DATA, 8'h22};
            if (k == 16) start = 1'b0;
            if (SS_n && ss_prev == 0 && rise == 0) rise = k;
            if (!SS_n && rise != 0 && fall2 == 0) fall2 = k;
            if (done) begin done_cnt++; if (first_done == 0) first_done = k; end
            ss_prev = int'(SS_n);
        end
        ref_apply({WR_DATA, 8'h11});
        ref_apply({WR_DATA, 8'h22});
        chk("b2b_first_rise", 32'(rise), 32'd14);
        chk("b2b_gap", 32'(fall2 - rise), 32'd2);
        chk("b2b_first_done", 32'(first_done), 32'd14);
        chk("b2b_done_count", 32'(done_cnt), 32'd2);
        run_frame({RD_DATA, 8'h00});
        chk("b2b_rd_22", 32'(rd_data), 32'h22);

        // Reset during an rd-data frame.
        @(negedge clk);
        start = 1'b1;
        cmd   = {RD_DATA, 8'h00};
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        chk("pre_reset_ss_low", 32'(SS_n), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ss_async", 32'(SS_n), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        bad_rd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || rd_valid) bad_rd++;
        end
        chk("abort_no_pulses", 32'(bad_rd), 32'd0);
        chk("abort_rd_data", 32'(rd_data), 32'd0);
        r_rd = 8'd0;
        run_frame({RD_DATA, 8'h00});
        chk("post_abort_rd", 32'(rd_data), 32'h22);

        // Randomized frames over a small address window so reads hit written data.
        for (int n = 0; n < 16; n++) begin
            op = 2'($urandom_range(0, 3));
            pl = (op == WR_DATA) ? 8'($urandom) : 8'($urandom_range(0, 3));
            run_frame({op, pl});
        end

        chk("ss_never_low_idle", 32'(ss_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter RD_WAIT, default 3: idle cycles between the last MOSI bit and the first MISO sample in a read-data frame (range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request a frame; sampled only in IDLE.
REQ-005 SHALL have port cmd  input  10  frame word: cmd[9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), cmd[7:0] payload.
REQ-006 SHALL have port busy  output  1  high from the acceptance cycle until the return to IDLE.
REQ-007 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-008 SHALL have port rd_data  output  8  byte received on MISO (rd-data frames only).
REQ-009 SHALL have port rd_valid  output  1  one-cycle pulse, coincident with done, for rd-data frames only.
REQ-010 SHALL have port SS_n  output  1  slave select, active low.
REQ-011 SHALL have port MOSI  output  1  serial data to slave, MSB first.
REQ-012 SHALL have port MISO  input  1  serial data from slave, MSB first.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have states IDLE, START, CMD, SHIFT, HOLD, WAIT, RECV and END.
REQ-015 In IDLE with start=1, the block SHALL latch cmd into a 10-bit shift register, set busy, and go to START; start SHALL be ignored in every other state.
REQ-016 START (1 cycle) SHALL drive SS_n=0 and MOSI=0.
REQ-017 CMD (1 cycle) SHALL drive MOSI=cmd[9] (read/write select bit).
REQ-018 SHIFT (10 cycles) SHALL drive MOSI=cmd[9], cmd[8], ... cmd[0], one bit per cycle, using a 4-bit down-counter loaded with 10.
REQ-019 After SHIFT, opcode != 11 SHALL go to HOLD; HOLD (1 cycle) SHALL keep SS_n=0 and MOSI=0 so the slave raises rx_valid, then go to END.
REQ-020 After SHIFT, opcode 11 SHALL go to WAIT for RD_WAIT cycles with MOSI=0, then to RECV.
REQ-021 RECV (8 cycles) SHALL shift MISO into rd_data MSB first, sampling at each posedge in RECV.
REQ-022 END (1 cycle) SHALL drive SS_n=1 and MOSI=0, pulse done, pulse rd_valid if the opcode was 11, and go to IDLE.
REQ-023 busy SHALL fall when the FSM enters IDLE, giving a minimum SS_n-high gap of 2 cycles between frames (END plus IDLE).
REQ-024 SS_n low duration SHALL be 13 cycles for opcodes 00/01/10 and 20+RD_WAIT cycles for opcode 11.
REQ-025 done SHALL assert 14 cycles after the acceptance edge for opcodes 00/01/10, and 21+RD_WAIT cycles after it for opcode 11.
REQ-026 rd_data SHALL hold its value until the next rd-data frame completes; other frame types SHALL NOT modify it.
REQ-027 A change on cmd after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, counters and shift register cleared.
REQ-029 Reset mid-frame SHALL abort the frame with no done or rd_valid pulse; SS_n SHALL rise without waiting for a clock.
REQ-030 The first start SHALL be accepted on the first posedge after rst_n deasserts.

Structure
REQ-031 Package spi_pkg SHALL hold: the state enum (shared with the slave bench), the opcode constants WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11, FRAME_BITS=10 and DATA_BITS=8.
REQ-032 One sub-module, spi_shifter (parallel-load, serial-out/serial-in shift register with bit counter), SHALL be instantiated for both the MOSI and MISO paths.

Verification
REQ-033 Write-address: cmd=10'h0A5, start 1 cycle -> SS_n low 13 cycles; MOSI sequence 0,0,0,0,1,0,1,0,0,1,0,1,0; done at cycle 14; no rd_valid.
REQ-034 Read-data against a slave model returning 8'hC3, RD_WAIT=3 -> SS_n low 23 cycles; rd_data=8'hC3 with rd_valid and done at cycle 24.
REQ-035 Back-to-back: start held high continuously across two wr-data frames -> second SS_n fall exactly 2 cycles after the first SS_n rise; start ignored while busy.
REQ-036 Reset at cycle 7 of an rd-data frame -> SS_n=1 immediately, no done or rd_valid, rd_data=0; a new frame then completes normally.
REQ-037 End-to-end loop with the slave: wr-addr 8'h10, wr-data 8'h5A, rd-addr 8'h10, rd-data -> rd_data=8'h5A; assertion that SS_n never falls while busy=0.
